// File: rtl/shift_div_pkg.sv
// Shared widths and state encoding for the shift_div restoring divider.
package shift_div_pkg;

  localparam int DIV_XLEN = 64;
  localparam int REG_BUS  = 2 * DIV_XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/shift_div_sub_step.sv
// One stateless restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_sub_step #(
  parameter int W = 65
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] shifted;

  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? W'(shifted - {1'b0, divisor_i}) : shifted[W-1:0];
  end

endmodule

// File: rtl/shift_div.sv
// 64-bit signed/unsigned sequential restoring divider, one quotient bit per cycle.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and (-2^63 / -1) straight from IDLE.
module shift_div
  import shift_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               rs1_sign,
  input  logic               rs2_sign,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  output logic               ready,
  output logic [REG_BUS-1:0] div_result
);

  localparam int CW = $clog2(XLEN);

  div_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     dvd_q, dvd_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic [XLEN:0]       dsr_q, dsr_d;
  logic                qSign_q, qSign_d;
  logic                rSign_q, rSign_d;
  logic                divZero_q, divZero_d;
  logic                ready_q, ready_d;
  logic [REG_BUS-1:0]  result_q, result_d;

  logic [XLEN-1:0]     rs1Mag;
  logic [XLEN:0]       rs2Mag;
  logic                rs2Zero;
  logic [XLEN:0]       stepRem;
  logic                stepBit;
  logic [XLEN-1:0]     quotFix, remFix;
`ifdef DIV_FAST_PATH_EN
  logic                ovfCase;
`endif

  div_sub_step #(.W(XLEN + 1)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[XLEN-1]),
    .divisor_i (dsr_q),
    .rem_o     (stepRem),
    .q_bit_o   (stepBit)
  );

  // Operands are {sign, data} 65-bit values; the dividend magnitude always fits in 64 bits.
  always_comb begin
    rs1Mag  = rs1_sign ? -rs1_data : rs1_data;
    rs2Mag  = rs2_sign ? -{rs2_sign, rs2_data} : {rs2_sign, rs2_data};
    rs2Zero = ({rs2_sign, rs2_data} == '0);
`ifdef DIV_FAST_PATH_EN
    ovfCase = rs1_sign && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
              rs2_sign && (rs2_data == '1);
`endif
    quotFix = divZero_q ? '1 : (qSign_q ? -dvd_q : dvd_q);
    remFix  = rSign_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    qSign_d   = qSign_q;
    rSign_d   = rSign_q;
    divZero_d = divZero_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          dvd_d     = rs1Mag;
          rem_d     = '0;
          dsr_d     = rs2Mag;
          qSign_d   = rs1_sign ^ rs2_sign;
          rSign_d   = rs1_sign;
          divZero_d = rs2Zero;
          cnt_d     = '0;
          state_d   = CALC;
`ifdef DIV_FAST_PATH_EN
          if (rs2Zero) begin
            result_d = {rs1_data, {XLEN{1'b1}}};
            state_d  = DONE;
          end else if (ovfCase) begin
            result_d = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            state_d  = DONE;
          end
`endif
        end
      end
      // The dividend register fills with quotient bits from the LSB as it shifts out.
      CALC: begin
        if (!valid) begin
          state_d = IDLE;
        end else begin
          dvd_d = {dvd_q[XLEN-2:0], stepBit};
          rem_d = stepRem;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (!valid) begin
          state_d = IDLE;
        end else begin
          result_d = {remFix, quotFix};
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      qSign_q   <= 1'b0;
      rSign_q   <= 1'b0;
      divZero_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      qSign_q   <= qSign_d;
      rSign_q   <= rSign_d;
      divZero_q <= divZero_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready      = ready_q;
  assign div_result = result_q;

endmodule

// File: tb/tb_shift_div.sv
// Scoreboard bench for shift_div: directed requests push expectations, a negedge monitor checks each ready pulse.
module tb_shift_div;

`ifdef DIV_FAST_PATH_EN
  localparam int LAT_FAST = 1;
`else
  localparam int LAT_FAST = 66;
`endif
  localparam int LAT_NORM = 66;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         rs1_sign, rs2_sign;
  logic [63:0]  rs1_data, rs2_data;
  logic         ready;
  logic [127:0] div_result;

  typedef struct {
    string       name;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   total = 0;
  int   bad = 0;
  int   waitEdges = 0;
  logic [127:0] prevResult;

  shift_div dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .rs1_sign   (rs1_sign),
    .rs2_sign   (rs2_sign),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .ready      (ready),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Monitor: counts edges since issue and checks every ready pulse against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      waitEdges = 0;
    end else if (expQ.size() == 0) begin
      waitEdges = 0;
      if (ready) checkOutput("unexpected_ready", 128'(ready), 128'(0));
    end else begin
      waitEdges++;
      if (ready) begin
        monE = expQ.pop_front();
        checkOutput({monE.name, "_quot"}, 128'(div_result[63:0]), 128'(monE.q));
        checkOutput({monE.name, "_rem"}, 128'(div_result[127:64]), 128'(monE.r));
        checkOutput({monE.name, "_lat"}, 128'(waitEdges), 128'(monE.lat));
        waitEdges = 0;
      end
    end
  end

  task automatic applyStimulus(input string name, input logic s1, input logic [63:0] d1,
                               input logic s2, input logic [63:0] d2,
                               input logic [63:0] eq, input logic [63:0] er, input int lat);
    exp_t e;
    bit   seen = 0;
    @(negedge clk); #1;
    rs1_sign = s1; rs1_data = d1; rs2_sign = s2; rs2_data = d2; valid = 1'b1;
    e.name = name; e.q = eq; e.r = er; e.lat = lat;
    expQ.push_back(e);
    @(posedge clk); #1;
    rs1_sign = ~s1; rs1_data = ~d1; rs2_sign = ~s2; rs2_data = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    if (!seen) begin
      checkOutput({name, "_timeout"}, 128'(0), 128'(1));
      expQ.delete();
    end
    #1 valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0;
    rs1_sign = 1'b0; rs2_sign = 1'b0; rs1_data = '0; rs2_data = '0;
    #12;
    checkOutput("reset_ready", 128'(ready), 128'(0));
    checkOutput("reset_result", div_result, 128'(0));
    @(negedge clk); rst = 1'b0;

    applyStimulus("u100_7", 1'b0, 64'd100, 1'b0, 64'd7, 64'd14, 64'd2, LAT_NORM);
    applyStimulus("sneg100_7", 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 1'b0, 64'd7,
                  64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, LAT_NORM);
    repeat (3) @(posedge clk);
    #1 checkOutput("hold_result", div_result, {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2});

    applyStimulus("sneg5_0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, LAT_FAST);
    applyStimulus("u12345_0", 1'b0, 64'd12345, 1'b0, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, LAT_FAST);
    applyStimulus("s_ovf", 1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 64'd0, LAT_FAST);
    applyStimulus("u_max_16", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h10,
                  64'h0FFF_FFFF_FFFF_FFFF, 64'hF, LAT_NORM);
    applyStimulus("s100_neg7", 1'b0, 64'd100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9,
                  64'hFFFF_FFFF_FFFF_FFF2, 64'd2, LAT_NORM);
    applyStimulus("u5_9", 1'b0, 64'd5, 1'b0, 64'd9, 64'd0, 64'd5, LAT_NORM);

    // Abort: drop valid after 20 CALC steps; no ready may follow and the result must hold.
    prevResult = div_result;
    @(negedge clk); #1;
    rs1_sign = 1'b0; rs1_data = 64'd1000; rs2_sign = 1'b0; rs2_data = 64'd3; valid = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_ready", 128'(ready), 128'(0));
    repeat (70) @(posedge clk);
    #1 checkOutput("abort_result_held", div_result, prevResult);
    applyStimulus("u9_3", 1'b0, 64'd9, 1'b0, 64'd3, 64'd3, 64'd0, LAT_NORM);

    // Asynchronous reset mid-CALC clears outputs without a clock edge.
    @(negedge clk); #1;
    rs1_sign = 1'b0; rs1_data = 64'd77; rs2_sign = 1'b0; rs2_data = 64'd5; valid = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1; valid = 1'b0;
    #1;
    checkOutput("midcalc_rst_ready", 128'(ready), 128'(0));
    checkOutput("midcalc_rst_result", div_result, 128'(0));
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus("u50_5", 1'b0, 64'd50, 1'b0, 64'd5, 64'd10, 64'd0, LAT_NORM);

    repeat (4) @(posedge clk);
    if (expQ.size() != 0) checkOutput("queue_drained", 128'(expQ.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
